// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and limits for the bit-serial adder
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seradd_state_e;

  localparam int SERADD_MAX_WIDTH = 32;

endpackage

// File: rtl/serial_add_seq_fulladd_slice.sv
// rtl/serial_add_seq_fulladd_slice.sv - one full-adder cell plus its carry register
module fulladd_slice (
  input  logic clk,
  input  logic resetl,
  input  logic a_i,
  input  logic b_i,
  input  logic ld_i,
  input  logic d_i,
  output logic q_o,
  output logic co_o,
  output logic cy_o
);

  logic cy_q;

  assign cy_o = cy_q;
  assign q_o  = a_i ^ b_i ^ cy_q;
  assign co_o = (a_i & b_i) | (cy_q & (a_i ^ b_i));

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      cy_q <= 1'b0;
    end else if (ld_i) begin
      cy_q <= d_i;
    end
  end

endmodule

// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - bit-serial add/subtract sequencer; SERADD_ACCUM_EN adds an accumulator operand
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetl,
`ifdef SERADD_ACCUM_EN
  input  logic             req_acc,
`endif
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_sub,
  input  logic             req_ci,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_co,
  output logic             res_ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  seradd_state_e    state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] op_a;
  logic             cy_ld, cy_val;
  logic             fa_q, fa_co, fa_cy;

`ifdef SERADD_ACCUM_EN
  logic [WIDTH-1:0] acc_q;

  assign op_a = req_acc ? acc_q : req_a;

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      acc_q <= '0;
    end else if ((state_q == DONE) && res_ready) begin
      acc_q <= sum_q;
    end
  end
`else
  assign op_a = req_a;
`endif

  fulladd_slice u_fa (
    .clk    (clk),
    .resetl (resetl),
    .a_i    (sa_q[0]),
    .b_i    (sb_q[0]),
    .ld_i   (cy_ld),
    .d_i    (cy_val),
    .q_o    (fa_q),
    .co_o   (fa_co),
    .cy_o   (fa_cy)
  );

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    co_d      = co_q;
    ovf_d     = ovf_q;
    cy_ld     = 1'b0;
    cy_val    = fa_co;
    req_ready = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          // Subtract is A + ~B + 1, so the inverted B and forced carry do it.
          sa_d    = op_a;
          sb_d    = req_sub ? ~req_b : req_b;
          cy_ld   = 1'b1;
          cy_val  = req_sub | req_ci;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d = {fa_q, sum_q[WIDTH-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cy_ld = 1'b1;
        if (cnt_q == CNT_LAST) begin
          co_d    = fa_co;
          ovf_d   = fa_cy ^ fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign res_sum = sum_q;
  assign res_co  = co_q;
  assign res_ovf = ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - self-checking bench for serial_add_seq (WIDTH=16)
module tb_serial_add_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         resetl;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a, req_b;
  logic         req_sub, req_ci;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_co, res_ovf;
`ifdef SERADD_ACCUM_EN
  logic         req_acc;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetl    (resetl),
`ifdef SERADD_ACCUM_EN
    .req_acc   (req_acc),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .req_ci    (req_ci),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_co    (res_co),
    .res_ovf   (res_ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         ci;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic on whole integers: unsigned for carry, signed for overflow.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sub, input logic ci,
                                output logic [W-1:0] s, output logic co, output logic ovf);
    longint ua, ub, sa, sb, t, st, smax, smin;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    if (sub) begin
      t  = ua - ub;
      co = (ua >= ub);
      st = sa - sb;
    end else begin
      t  = ua + ub + longint'(ci);
      co = (t >= (longint'(1) <<< W));
      st = sa + sb + longint'(ci);
    end
    s   = t[W-1:0];
    ovf = (st > smax) || (st < smin);
  endfunction

  task automatic scramble();
    req_valid = 1'($urandom);
    req_a     = W'($urandom);
    req_b     = W'($urandom);
    req_sub   = 1'($urandom);
    req_ci    = 1'($urandom);
    res_ready = 1'($urandom);
`ifdef SERADD_ACCUM_EN
    req_acc   = 1'($urandom);
`endif
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic ci, input logic acc, input int stall,
                        output logic [W-1:0] s, output logic co, output logic ovf);
    int lat;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_request", req_ready, 1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_sub   = sub;
    req_ci    = ci;
    res_ready = 1'b0;
`ifdef SERADD_ACCUM_EN
    req_acc   = acc;
`else
    if (acc) $display("note: accumulator request ignored in this build");
`endif
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("accepted", req_ready, 0);
      scramble();
    end while (!res_valid && lat < 40);
    res_ready = 1'b0;
    chk("latency", lat, W + 1);
    s   = res_sum;
    co  = res_co;
    ovf = res_ovf;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_hold", {res_valid, req_ready, res_sum, res_co, res_ovf},
          {1'b1, 1'b0, s, co, ovf});
      req_valid = 1'b1;
      req_a     = W'($urandom);
      req_b     = W'($urandom);
    end
    res_ready = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    req_valid = 1'b0;
    chk("handshake_to_idle", {res_valid, req_ready}, 2'b01);
  endtask

  vec_t         vecs[$];
  logic [W-1:0] s, es;
  logic         co, ovf, eco, eovf;
  logic         seen;

  initial begin
    resetl = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0;
    req_sub = 1'b0; req_ci = 1'b0; res_ready = 1'b0;
`ifdef SERADD_ACCUM_EN
    req_acc = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_state", {req_ready, res_valid, res_sum, res_co, res_ovf},
        {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
    resetl = 1'b1;

    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0});
    vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1});
    vecs.push_back('{16'h0003, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0});
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].ci, 1'b0, 0, s, co, ovf);
      chk("vec_sum", s, vecs[i].sum);
      chk("vec_co", co, vecs[i].co);
      chk("vec_ovf", ovf, vecs[i].ovf);
    end

    // Abort during the 8th RUN cycle: reset must clear outputs at once.
    @(negedge clk);
    req_valid = 1'b1; req_a = 16'hFFFF; req_b = 16'hFFFF; req_sub = 1'b0; req_ci = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    resetl = 1'b0;
    #1;
    chk("abort_outputs", {req_ready, res_valid, res_sum, res_co, res_ovf},
        {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
    @(negedge clk);
    resetl = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    chk("no_result_after_abort", seen, 1'b0);

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 5, s, co, ovf);
    chk("stall_sum", {s, co, ovf}, {16'h5555, 1'b0, 1'b0});

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] a, b;
      logic sub, ci;
      int stall;
      a = W'($urandom); b = W'($urandom);
      sub = 1'($urandom); ci = 1'($urandom);
      stall = int'($urandom_range(0, 2));
      model(a, b, sub, ci, es, eco, eovf);
      run_op(a, b, sub, ci, 1'b0, stall, s, co, ovf);
      chk("rand_result", {s, co, ovf}, {es, eco, eovf});
    end

`ifdef SERADD_ACCUM_EN
    run_op(16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, 0, s, co, ovf);
    chk("acc_first", s, 16'h0030);
    run_op(16'hABCD, 16'h0005, 1'b0, 1'b0, 1'b1, 0, s, co, ovf);
    chk("acc_plus_b", s, 16'h0035);
    run_op(16'h1111, 16'h0000, 1'b0, 1'b0, 1'b1, 0, s, co, ovf);
    chk("acc_value", s, 16'h0035);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
